// File: rtl/network_port_arbiter_if.sv
// Signal bundle between the ingress requesters and the packet-buffer write arbiter.
// The slave view belongs to the arbiter; the master view belongs to the requester side.
interface network_port_arbiter_if #(
    parameter int NUM_PORTS = 4
);
    logic [NUM_PORTS-1:0]   req;
    logic [NUM_PORTS*4-1:0] req_dest;
    logic                   credit_return;
    logic [NUM_PORTS-1:0]   grant;
    logic                   out_valid;
    logic                   out_last;
    logic [3:0]             out_dest;
    logic [2:0]             out_src;
    logic [7:0]             credit_cnt;
    logic                   route_error;
    logic [2:0]             err_src;
    logic                   credit_overflow;

    modport master (
        output req, req_dest, credit_return,
        input  grant, out_valid, out_last, out_dest, out_src,
               credit_cnt, route_error, err_src, credit_overflow
    );

    modport slave (
        input  req, req_dest, credit_return,
        output grant, out_valid, out_last, out_dest, out_src,
               credit_cnt, route_error, err_src, credit_overflow
    );
endinterface

// File: rtl/network_port_arbiter.sv
// Round-robin whole-packet scheduler for the shared packet-buffer write port,
// with downstream credit accounting and rejection of unroutable destinations.
module network_port_arbiter #(
    parameter int          NUM_PORTS = 4,
    parameter int          PKT_BEATS = 8,
    parameter int          CREDITS   = 16,
    parameter logic [15:0] DEST_MASK = 16'hFFFF
) (
    input logic                   clk,
    input logic                   rst,
    network_port_arbiter_if.slave bus
);
    localparam logic [2:0] LAST_PORT  = 3'(NUM_PORTS - 1);
    localparam logic [7:0] LAST_BEAT  = 8'(PKT_BEATS - 1);
    localparam logic [7:0] CREDIT_MAX = 8'(CREDITS);

    typedef enum logic {IDLE, XFER} state_t;

    state_t               state_reg, state_next;
    logic [2:0]           rr_ptr_reg, rr_ptr_next;
    logic [7:0]           beat_reg, beat_next;
    logic [7:0]           credit_reg, credit_next;
    logic [NUM_PORTS-1:0] grant_reg, grant_next;
    logic                 valid_reg, valid_next;
    logic [3:0]           dest_reg, dest_next;
    logic [2:0]           src_reg, src_next;
    logic                 route_err_reg, route_err_next;
    logic [2:0]           err_src_reg, err_src_next;
    logic                 overflow_reg, overflow_next;

    logic [7:0]           req_ext;
    logic [31:0]          dest_ext;
    logic [NUM_PORTS-1:0] rot_req;
    logic [2:0]           rot_idx [NUM_PORTS];
    logic                 found;
    logic [2:0]           win_idx;
    logic [3:0]           win_dest;
    logic                 take;

    function automatic logic [2:0] inc_port(input logic [2:0] p);
        return (p == LAST_PORT) ? 3'd0 : p + 3'd1;
    endfunction

    assign req_ext  = 8'(bus.req);
    assign dest_ext = 32'(bus.req_dest);

    // Slot gi of the rotated view is the port gi positions after rr_ptr.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_rot
            logic [3:0] sum;
            assign sum         = {1'b0, rr_ptr_reg} + 4'(gi);
            assign rot_idx[gi] = (sum >= 4'(NUM_PORTS)) ? 3'(sum - 4'(NUM_PORTS)) : sum[2:0];
            assign rot_req[gi] = req_ext[rot_idx[gi]];
        end
    endgenerate

    // Walk from the far end so the slot nearest rr_ptr wins.
    always_comb begin
        found   = 1'b0;
        win_idx = 3'd0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (rot_req[i]) begin
                found   = 1'b1;
                win_idx = rot_idx[i];
            end
        end
        win_dest = dest_ext[{win_idx, 2'b00} +: 4];
    end

    always_comb begin
        state_next     = state_reg;
        rr_ptr_next    = rr_ptr_reg;
        beat_next      = beat_reg;
        grant_next     = grant_reg;
        valid_next     = valid_reg;
        dest_next      = dest_reg;
        src_next       = src_reg;
        route_err_next = 1'b0;
        err_src_next   = err_src_reg;
        overflow_next  = overflow_reg;
        credit_next    = credit_reg;
        take           = 1'b0;

        case (state_reg)
            IDLE: begin
                if (found && credit_reg != 8'd0) begin
                    if (DEST_MASK[win_dest]) begin
                        take       = 1'b1;
                        state_next = XFER;
                        grant_next = NUM_PORTS'(1) << win_idx;
                        valid_next = 1'b1;
                        dest_next  = win_dest;
                        src_next   = win_idx;
                        beat_next  = LAST_BEAT;
                    end else begin
                        route_err_next = 1'b1;
                        err_src_next   = win_idx;
                        rr_ptr_next    = inc_port(win_idx);
                    end
                end
            end
            XFER: begin
                if (beat_reg == 8'd0) begin
                    state_next  = IDLE;
                    grant_next  = '0;
                    valid_next  = 1'b0;
                    rr_ptr_next = inc_port(src_reg);
                end else begin
                    beat_next = beat_reg - 8'd1;
                end
            end
        endcase

        // A grant and a returned slot in the same cycle cancel out.
        if (take && !bus.credit_return) begin
            credit_next = credit_reg - 8'd1;
        end else if (!take && bus.credit_return) begin
            if (credit_reg == CREDIT_MAX) begin
                overflow_next = 1'b1;
            end else begin
                credit_next = credit_reg + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= 3'd0;
            beat_reg      <= 8'd0;
            credit_reg    <= CREDIT_MAX;
            grant_reg     <= '0;
            valid_reg     <= 1'b0;
            dest_reg      <= 4'd0;
            src_reg       <= 3'd0;
            route_err_reg <= 1'b0;
            err_src_reg   <= 3'd0;
            overflow_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rr_ptr_reg    <= rr_ptr_next;
            beat_reg      <= beat_next;
            credit_reg    <= credit_next;
            grant_reg     <= grant_next;
            valid_reg     <= valid_next;
            dest_reg      <= dest_next;
            src_reg       <= src_next;
            route_err_reg <= route_err_next;
            err_src_reg   <= err_src_next;
            overflow_reg  <= overflow_next;
        end
    end

    assign bus.grant           = grant_reg;
    assign bus.out_valid       = valid_reg;
    assign bus.out_last        = valid_reg && (beat_reg == 8'd0);
    assign bus.out_dest        = dest_reg;
    assign bus.out_src         = src_reg;
    assign bus.credit_cnt      = credit_reg;
    assign bus.route_error     = route_err_reg;
    assign bus.err_src         = err_src_reg;
    assign bus.credit_overflow = overflow_reg;
endmodule
